// File: rtl/conv_loop_sequencer.sv
// Convolution loop sequencer: walks i/j/k/m/n/l one tap per cycle, flags padding,
// accumulator clear and last tap, and delays the last-tap strobe into en_save.
module conv_loop_sequencer #(
  parameter int CONV_DIM_IMG    = 32,
  parameter int CONV_DIM_KERNEL = 5,
  parameter int CONV_DIM_CH     = 3,
  parameter int CONV_OUT_CH     = 32,
  parameter int CONV_DIM_OUT    = 32,
  parameter int STRIDE          = 1,
  parameter int PADDING         = 2,
  parameter int SAVE_LAT        = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stall,
  output logic       busy,
  output logic       done,
  output logic       enable,
  output logic       en_save,
  output logic [7:0] i,
  output logic [7:0] j,
  output logic [7:0] k,
  output logic [7:0] l,
  output logic [7:0] m,
  output logic [7:0] n,
  output logic       tap_valid,
  output logic       acc_clear,
  output logic       last_tap,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  localparam logic [7:0]  CH_MAX  = 8'(CONV_DIM_CH - 1);
  localparam logic [7:0]  K_MAX   = 8'(CONV_DIM_KERNEL - 1);
  localparam logic [7:0]  OUT_MAX = 8'(CONV_DIM_OUT - 1);
  localparam logic [7:0]  OCH_MAX = 8'(CONV_OUT_CH - 1);
  localparam logic [15:0] STR_W   = 16'(STRIDE);
  localparam logic [15:0] PAD_W   = 16'(PADDING);
  localparam logic [15:0] IMG_W   = 16'(CONV_DIM_IMG);

  state_t              state;
  logic [SAVE_LAT-1:0] save_sr;
  logic                wrap_l, wrap_n, wrap_m, wrap_k, wrap_j, final_tap;
  logic [15:0]         row, col;

  assign state_dbg = state;
  assign enable    = (state == S_RUN) && !stall;
  assign en_save   = save_sr[SAVE_LAT-1];

  // Flags are gated by RUN so they read 0 in idle/reset even though the indices are 0.
  assign acc_clear = (state == S_RUN) && (m == 8'd0) && (n == 8'd0) && (l == 8'd0);
  assign last_tap  = (state == S_RUN) && (m == K_MAX) && (n == K_MAX) && (l == CH_MAX);

  assign wrap_l    = (l == CH_MAX);
  assign wrap_n    = wrap_l && (n == K_MAX);
  assign wrap_m    = wrap_n && (m == K_MAX);
  assign wrap_k    = wrap_m && (k == OUT_MAX);
  assign wrap_j    = wrap_k && (j == OUT_MAX);
  assign final_tap = wrap_j && (i == OCH_MAX);

  assign row = 16'(STR_W * {8'd0, j}) + {8'd0, m};
  assign col = 16'(STR_W * {8'd0, k}) + {8'd0, n};
  assign tap_valid = (row >= PAD_W) && ((row - PAD_W) < IMG_W) &&
                     (col >= PAD_W) && ((col - PAD_W) < IMG_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      save_sr <= '0;
      i <= 8'd0; j <= 8'd0; k <= 8'd0; l <= 8'd0; m <= 8'd0; n <= 8'd0;
    end else begin
      // The save delay line runs every cycle so stalls never shift en_save timing.
      save_sr <= SAVE_LAT'({save_sr, enable && last_tap});
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
            i <= 8'd0; j <= 8'd0; k <= 8'd0; l <= 8'd0; m <= 8'd0; n <= 8'd0;
          end
        end
        S_RUN: begin
          if (enable) begin
            if (final_tap) begin
              state <= S_DRAIN;
            end else begin
              l <= wrap_l ? 8'd0 : l + 8'd1;
              if (wrap_l) n <= wrap_n ? 8'd0 : n + 8'd1;
              if (wrap_n) m <= wrap_m ? 8'd0 : m + 8'd1;
              if (wrap_m) k <= wrap_k ? 8'd0 : k + 8'd1;
              if (wrap_k) j <= wrap_j ? 8'd0 : j + 8'd1;
              if (wrap_j) i <= i + 8'd1;
            end
          end
        end
        S_DRAIN: begin
          if (save_sr == '0) begin
            state <= S_FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_loop_sequencer.md
Name: conv_loop_sequencer

Overview:
- Control stage directly upstream of the conv address generator.
- Walks the six nested convolution loop indices one tap per cycle: i (output channel), j (output row), k (output column), m (kernel row), n (kernel column), l (input channel). l is the innermost loop.
- Drives enable, en_save and the index buses into the address generator.
- Flags padding taps, accumulator clear and last tap for the MAC datapath, and runs a start/busy/done handshake with the layer scheduler.

Parameters:
- CONV_DIM_IMG, 32, input image height/width in pixels.
- CONV_DIM_KERNEL, 5, kernel height/width.
- CONV_DIM_CH, 3, input channels.
- CONV_OUT_CH, 32, output channels.
- CONV_DIM_OUT, 32, output height/width.
- STRIDE, 1, convolution stride.
- PADDING, 2, zero padding on each image edge.
- SAVE_LAT, 2, cycles from the last-tap issue cycle to the en_save pulse (range 1..7).

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to run one full layer.
- stall  in  1  freezes index advance while high.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the layer is complete.
- enable  out  1  current indices form a valid tap to issue.
- en_save  out  1  save strobe for one output pixel.
- i, j, k, l, m, n  out  8 each  loop indices.
- tap_valid  out  1  current tap lies inside the unpadded image.
- acc_clear  out  1  current tap is the first tap of an output pixel.
- last_tap  out  1  current tap is the final tap of an output pixel.

Behaviour:
- Reset: state IDLE. All indices 0. busy, done, enable, en_save, acc_clear and last_tap are 0. The save delay line is flushed.
- Reset asserted mid-run aborts the layer: no further en_save and no done are produced.
- The FSM has four states:
  - IDLE: waits for start. start=1 loads all indices to 0 and goes to RUN. busy=1 from the next cycle.
  - RUN: enable=~stall.
    - When enable=1, the indices advance at the clock edge. l increments. When l wraps from CONV_DIM_CH-1 to 0, n increments, and the carry continues through n, m, k, j, i with limits CONV_DIM_KERNEL, CONV_DIM_KERNEL, CONV_DIM_OUT, CONV_DIM_OUT, CONV_OUT_CH.
    - When stall=1, all indices and flags hold their values.
    - Issuing the tap i=CONV_OUT_CH-1, j=k=CONV_DIM_OUT-1, m=n=CONV_DIM_KERNEL-1, l=CONV_DIM_CH-1 moves to DRAIN. The indices hold that final tap.
  - DRAIN: enable=0. Waits until the delay line is empty, then goes to DONE.
  - DONE: done=1 for one cycle, busy drops, then IDLE.
- start is ignored unless the state is IDLE.
- acc_clear = (m==0 && n==0 && l==0). last_tap = (m==K-1 && n==K-1 && l==CH-1). Both flags are valid whenever enable=1.
- tap_valid is combinational from the index registers:
  - row = STRIDE*j + m, col = STRIDE*k + n, both computed at 16 bits.
  - tap_valid = row ≥ PADDING && row−PADDING < CONV_DIM_IMG && col ≥ PADDING && col−PADDING < CONV_DIM_IMG.
- en_save timing:
  - A SAVE_LAT-deep shift register advances every cycle, stall or not.
  - It is loaded with (enable && last_tap). en_save is its output.
  - Result: exactly one en_save per output pixel, SAVE_LAT cycles after that pixel's last tap is issued.
- Throughput: one tap per cycle with no stall. Total RUN cycles with no stall = CONV_OUT_CH·CONV_DIM_OUT²·CONV_DIM_KERNEL²·CONV_DIM_CH.
- Index registers are 8 bits. Parameters must keep every index ≤255.

Test Plan:
- Small config (IMG=4, K=3, CH=2, OUT_CH=2, OUT=4, STRIDE=1, PAD=1), start pulse, no stall → enable high for exactly 576 consecutive cycles; 32 en_save pulses, each 2 cycles after a last_tap; done is one pulse; busy is low afterwards.
- Same config, check the first tap and the tap at j=0,k=0,m=1,n=1 → first tap: tap_valid=0 (row=0 falls in padding). Tap at m=1,n=1: tap_valid=1. Corner taps at j=3,k=3,m=2 → tap_valid=0.
- Random stall at 30% density → indices hold while stalled; the index sequence matches the no-stall golden sequence; the en_save count is still 32; done fires once.
- Reset asserted at tap 100 → next cycle: state IDLE, indices 0, no en_save and no done afterwards. A fresh start then produces a full 576-tap run.
- start re-pulsed during RUN and DRAIN → ignored; the index sequence is undisturbed; exactly one done.
- Stall held high during DRAIN after the final tap → the final en_save still fires SAVE_LAT cycles after the last tap; done follows.
